// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit: state encoding,
// opcode classes and the opcode classifier.
package ctrl_pkg;

  localparam logic [1:0] ST_FETCH  = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_EXEC   = 2'd2;
  localparam logic [1:0] ST_WB     = 2'd3;

  typedef enum logic [1:0] {
    CLS_NOP = 2'd0,
    CLS_ALU = 2'd1,
    CLS_BR  = 2'd2
  } opclass_t;

  // Opcode is passed zero-extended to 32 bits; width selects the all-ones branch code.
  function automatic opclass_t classify_opcode(input logic [31:0] opc,
                                               input int unsigned width);
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF >> (32 - width);
    if (opc == '0)
      return CLS_NOP;
    else if (opc == ones)
      return CLS_BR;
    else
      return CLS_ALU;
  endfunction

endpackage

// File: rtl/exec_timer.sv
// Loadable down-counter with a done flag marking the final counted cycle.
module exec_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load)
      count_d = load_val;
    else if (en && (count_q != '0))
      count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign count = count_q;
  assign done  = (count_q == CNT_W'(1));

endmodule

// File: rtl/multicycle_control_unit.sv
// FETCH/DECODE/EXEC/WB sequencer driving datapath strobes.
// Optional retire/taken-branch counters when CTRL_PERF_CNT_EN is defined.
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W    = 4,
  parameter int unsigned ALUOP_W     = 2,
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instrValid,
  output logic                instrReady,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                hold,
  input  logic                zeroFlag,
  output logic                irWrite,
  output logic                aluStart,
  output logic [ALUOP_W-1:0]  aluOp,
  output logic                regWrite,
  output logic                branch,
  output logic                pcWrite,
  output logic [1:0]          state
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [15:0]         retireCount,
  output logic [15:0]         takenCount
`endif
);

  localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES);

  logic [1:0]          state_q, state_d;
  logic [OPCODE_W-1:0] opc_q, opc_d;
  opclass_t            cls_q, cls_d;

  logic       accept;
  logic       tmr_load, tmr_en, tmr_done;
  logic [3:0] tmr_count;

  exec_timer #(.CNT_W(4)) u_exec_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (EXEC_LOAD),
    .en       (tmr_en),
    .count    (tmr_count),
    .done     (tmr_done)
  );

  assign accept = instrReady && instrValid;

  always_comb begin
    state_d  = state_q;
    opc_d    = opc_q;
    cls_d    = cls_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (accept) begin
          opc_d   = opcode;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!hold) begin
          cls_d    = classify_opcode(32'(opc_q), OPCODE_W);
          tmr_load = 1'b1;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!hold) begin
          tmr_en = 1'b1;
          if (tmr_done)
            state_d = ST_WB;
        end
      end
      default: begin
        if (!hold)
          state_d = ST_FETCH;
      end
    endcase
  end

  // Strobes decode registered state only; hold masks them so the frozen cycle replays once.
  always_comb begin
    instrReady = (state_q == ST_FETCH) && !hold;
    irWrite    = accept;
    aluStart   = (state_q == ST_EXEC) && !hold && (tmr_count == EXEC_LOAD);
    pcWrite    = (state_q == ST_WB) && !hold;
    regWrite   = pcWrite && (cls_q == CLS_ALU);
    branch     = pcWrite && (cls_q == CLS_BR) && zeroFlag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      opc_q   <= '0;
      cls_q   <= CLS_NOP;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      cls_q   <= cls_d;
    end
  end

  assign aluOp = opc_q[ALUOP_W-1:0];
  assign state = state_q;

`ifdef CTRL_PERF_CNT_EN
  logic [15:0] retire_q, retire_d, taken_q, taken_d;

  always_comb begin
    retire_d = retire_q;
    taken_d  = taken_q;
    if (pcWrite)
      retire_d = retire_q + 16'd1;
    if (branch)
      taken_d = taken_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_q <= '0;
      taken_q  <= '0;
    end else begin
      retire_q <= retire_d;
      taken_q  <= taken_d;
    end
  end

  assign retireCount = retire_q;
  assign takenCount  = taken_q;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized self-checking bench for multicycle_control_unit with EXEC_CYCLES=1 and 4.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instrValid = 1'b0;
  logic [3:0] opcode = '0;
  logic       hold = 1'b0;
  logic       zeroFlag = 1'b0;

  logic       rdy [2];
  logic       irw [2];
  logic       ast [2];
  logic [1:0] aop [2];
  logic       rgw [2];
  logic       brn [2];
  logic       pcw [2];
  logic [1:0] st  [2];
`ifdef CTRL_PERF_CNT_EN
  logic [15:0] rcnt [2];
  logic [15:0] tcnt [2];
`endif

  always #5 clk = ~clk;

  multicycle_control_unit #(.OPCODE_W(4), .ALUOP_W(2), .EXEC_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .instrValid(instrValid), .instrReady(rdy[0]),
    .opcode(opcode), .hold(hold), .zeroFlag(zeroFlag), .irWrite(irw[0]),
    .aluStart(ast[0]), .aluOp(aop[0]), .regWrite(rgw[0]), .branch(brn[0]),
    .pcWrite(pcw[0]), .state(st[0])
`ifdef CTRL_PERF_CNT_EN
    , .retireCount(rcnt[0]), .takenCount(tcnt[0])
`endif
  );

  multicycle_control_unit #(.OPCODE_W(4), .ALUOP_W(2), .EXEC_CYCLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .instrValid(instrValid), .instrReady(rdy[1]),
    .opcode(opcode), .hold(hold), .zeroFlag(zeroFlag), .irWrite(irw[1]),
    .aluStart(ast[1]), .aluOp(aop[1]), .regWrite(rgw[1]), .branch(brn[1]),
    .pcWrite(pcw[1]), .state(st[1])
`ifdef CTRL_PERF_CNT_EN
    , .retireCount(rcnt[1]), .takenCount(tcnt[1])
`endif
  );

  // Reference model: each instruction is a sequence of steps 0..E+2
  // (0 = waiting for an opcode, 1 = decode, 2..E+1 = execute, E+2 = writeback).
  int          exec_len [2] = '{1, 4};
  int          step     [2];
  logic [3:0]  m_opc    [2];
  logic [15:0] m_retire [2];
  logic [15:0] m_taken  [2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      step[d]     = 0;
      m_opc[d]    = '0;
      m_retire[d] = '0;
      m_taken[d]  = '0;
    end
  endtask

  task automatic check_and_advance(input int d);
    int   e, s;
    logic live, wb, is_alu, is_br;
    logic [1:0] exp_st;
    logic exp_irw, exp_ast, exp_pcw, exp_rgw, exp_brn;
    string p;
    e      = exec_len[d];
    s      = step[d];
    p      = (d == 0) ? "e1" : "e4";
    live   = rst_n && !hold;
    wb     = (s == e + 2);
    is_alu = (m_opc[d] != 4'h0) && (m_opc[d] != 4'hF);
    is_br  = (m_opc[d] == 4'hF);
    exp_st  = (s == 0) ? 2'd0 : (s == 1) ? 2'd1 : (s <= e + 1) ? 2'd2 : 2'd3;
    exp_irw = (s == 0) && live && instrValid;
    exp_ast = (s == 2) && live;
    exp_pcw = wb && live;
    exp_rgw = exp_pcw && is_alu;
    exp_brn = exp_pcw && is_br && zeroFlag;

    check({p, "_state"},    32'(st[d]),  32'(exp_st));
    check({p, "_irWrite"},  32'(irw[d]), 32'(exp_irw));
    check({p, "_aluStart"}, 32'(ast[d]), 32'(exp_ast));
    check({p, "_aluOp"},    32'(aop[d]), 32'(m_opc[d][1:0]));
    check({p, "_regWrite"}, 32'(rgw[d]), 32'(exp_rgw));
    check({p, "_branch"},   32'(brn[d]), 32'(exp_brn));
    check({p, "_pcWrite"},  32'(pcw[d]), 32'(exp_pcw));
    if (rst_n)
      check({p, "_instrReady"}, 32'(rdy[d]), 32'((s == 0) && !hold));
`ifdef CTRL_PERF_CNT_EN
    check({p, "_retireCount"}, 32'(rcnt[d]), 32'(m_retire[d]));
    check({p, "_takenCount"},  32'(tcnt[d]), 32'(m_taken[d]));
`endif

    if (live) begin
      if (exp_pcw) m_retire[d] = m_retire[d] + 16'd1;
      if (exp_brn) m_taken[d]  = m_taken[d] + 16'd1;
      if (s == 0) begin
        if (instrValid) begin
          m_opc[d] = opcode;
          step[d]  = 1;
        end
      end else if (wb) begin
        step[d] = 0;
      end else begin
        step[d] = s + 1;
      end
    end
  endtask

  function automatic logic in_reset(input int cyc);
    return (cyc < 3) || (cyc >= 700 && cyc < 703) || (cyc >= 1400 && cyc < 1403);
  endfunction

  function automatic logic in_idle(input int cyc);
    return (cyc >= 3 && cyc < 8) || (cyc >= 703 && cyc < 708) || (cyc >= 1403 && cyc < 1408);
  endfunction

  initial begin
    model_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      if (in_reset(cyc)) begin
        rst_n      = 1'b0;
        instrValid = 1'b0;
        hold       = 1'b0;
        zeroFlag   = 1'($urandom_range(0, 1));
        opcode     = 4'($urandom_range(0, 15));
        model_reset();
      end else if (in_idle(cyc)) begin
        rst_n      = 1'b1;
        instrValid = 1'b0;
        hold       = 1'b0;
        zeroFlag   = 1'($urandom_range(0, 1));
        opcode     = 4'($urandom_range(0, 15));
      end else begin
        int sel;
        rst_n      = 1'b1;
        hold       = ($urandom_range(0, 9) < 2);
        instrValid = ($urandom_range(0, 9) < 6);
        zeroFlag   = 1'($urandom_range(0, 1));
        sel        = int'($urandom_range(0, 3));
        opcode     = (sel == 0) ? 4'h0 : (sel == 1) ? 4'hF : 4'($urandom_range(0, 15));
      end
      #1;
      check_and_advance(0);
      check_and_advance(1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
